// File: rtl/uart_core_fifo_if.sv
// rtl/uart_core_fifo_if.sv - host-side TX/RX stream handshake bundle for the UART core
interface uart_core_fifo_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;

    modport master (output tx_valid, tx_data, rx_ready, input tx_ready, rx_valid, rx_data);
    modport slave  (input tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/uart_core_fifo.sv
// rtl/uart_core_fifo.sv - single-clock UART core with 16x oversampled RX and TX/RX FIFOs
module uart_core_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       length,
    input  logic             parity_en,
    input  logic             parity_type,
    input  logic             stop2,
    input  logic             loopback,
    uart_core_fifo_if.slave  host,
    output logic             txd,
    input  logic             rxd,
    output logic             tx_busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       len_eff;

    assign tick    = (div_cnt >= baud_div);
    assign len_eff = (length < 4'd5 || length > 4'(DATA_W)) ? 4'(DATA_W) : length;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // TX FIFO
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp, tx_rp;
    logic [AW:0]       tx_cnt;
    logic              tx_push, tx_pop;
    logic [DATA_W-1:0] tx_mask, tx_word;

    assign host.tx_ready = (tx_cnt != DEPTH);
    assign tx_push       = host.tx_valid && host.tx_ready;
    assign tx_mask       = (DATA_W'(1) << len_eff) - DATA_W'(1);
    assign tx_word       = tx_mem[tx_rp] & tx_mask;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= host.tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
        end
    end

    // TX FSM
    tx_state_t         tx_state, tx_next;
    logic [3:0]        tx_tcnt, tx_bcnt, tx_len;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_pen, tx_st2, tx_par, tx_bend, tx_have;

    assign tx_bend = tick && (tx_tcnt == 4'hF);
    assign tx_have = (tx_cnt != '0);
    assign tx_busy = (tx_state != T_IDLE) || tx_have;

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        txd     = 1'b1;
        case (tx_state)
            T_IDLE:  if (tick && tx_have) begin tx_next = T_START; tx_pop = 1'b1; end
            T_START: begin txd = 1'b0; if (tx_bend) tx_next = T_DATA; end
            T_DATA: begin
                txd = tx_sh[0];
                if (tx_bend && tx_bcnt == tx_len - 4'd1) tx_next = tx_pen ? T_PAR : T_STOP1;
            end
            T_PAR:   begin txd = tx_par; if (tx_bend) tx_next = T_STOP1; end
            T_STOP1, T_STOP2: begin
                if (tx_bend) begin
                    if (tx_state == T_STOP1 && tx_st2) tx_next = T_STOP2;
                    else if (tx_have) begin tx_next = T_START; tx_pop = 1'b1; end
                    else tx_next = T_IDLE;
                end
            end
            default: tx_next = T_IDLE;
        endcase
    end

    // Frame config and word are captured on the pop so mid-frame changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_len   <= 4'(DATA_W);
            tx_sh    <= '0;
            tx_pen   <= 1'b0;
            tx_st2   <= 1'b0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_sh   <= tx_word;
                tx_par  <= (^tx_word) ^ parity_type;
                tx_len  <= len_eff;
                tx_pen  <= parity_en;
                tx_st2  <= stop2;
                tx_tcnt <= '0;
                tx_bcnt <= '0;
            end else if (tick) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_bend && tx_state == T_DATA) begin
                    tx_sh   <= tx_sh >> 1;
                    tx_bcnt <= tx_bcnt + 4'd1;
                end
            end
        end
    end

    // RX line: loopback goes through the same two stages so timing matches rxd.
    logic [1:0] rx_sync;
    logic       rx_line, rx_prev;
    assign rx_line = rx_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], loopback ? txd : rxd};
            rx_prev <= rx_line;
        end
    end

    // RX FIFO
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wp, rx_rp;
    logic [AW:0]       rx_cnt;
    logic              rx_push, rx_pop, rx_full;
    logic [DATA_W-1:0] rx_sh, rx_word;

    assign rx_full      = (rx_cnt == DEPTH);
    assign host.rx_valid = (rx_cnt != '0);
    assign host.rx_data  = host.rx_valid ? rx_mem[rx_rp] : '0;
    assign rx_pop        = host.rx_valid && host.rx_ready;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
        end
    end

    // RX FSM
    rx_state_t  rx_state, rx_next;
    logic [3:0] rx_tcnt, rx_bcnt, rx_len;
    logic       rx_pen, rx_ptype, rx_pbad, rx_samp, rx_bend;
    logic       pe_set, fe_set, ov_set;

    assign rx_samp = tick && (rx_tcnt == 4'd7);
    assign rx_bend = tick && (rx_tcnt == 4'hF);
    assign rx_word = rx_sh >> (4'(DATA_W) - rx_len);

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        pe_set  = 1'b0;
        fe_set  = 1'b0;
        ov_set  = 1'b0;
        case (rx_state)
            R_IDLE:  if (rx_prev && !rx_line) rx_next = R_START;
            R_START: begin
                if (rx_samp && rx_line) rx_next = R_IDLE;
                else if (rx_bend)       rx_next = R_DATA;
            end
            R_DATA:  if (rx_bend && rx_bcnt == rx_len - 4'd1) rx_next = rx_pen ? R_PAR : R_STOP;
            R_PAR:   if (rx_bend) rx_next = R_STOP;
            R_STOP: begin
                if (rx_samp) begin
                    rx_next = R_IDLE;
                    if (!rx_line)               begin fe_set = 1'b1; rx_next = R_WAIT; end
                    else if (rx_pen && rx_pbad) pe_set  = 1'b1;
                    else if (rx_full)           ov_set  = 1'b1;
                    else                        rx_push = 1'b1;
                end
            end
            R_WAIT:  if (rx_line) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // Config tracks the inputs while idle, so it holds the values present at START entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= R_IDLE;
            rx_tcnt    <= '0;
            rx_bcnt    <= '0;
            rx_sh      <= '0;
            rx_len     <= 4'(DATA_W);
            rx_pen     <= 1'b0;
            rx_ptype   <= 1'b0;
            rx_pbad    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            parity_err <= pe_set;
            frame_err  <= fe_set;
            overrun    <= ov_set;
            if (rx_state == R_IDLE) begin
                rx_tcnt  <= '0;
                rx_bcnt  <= '0;
                rx_sh    <= '0;
                rx_len   <= len_eff;
                rx_pen   <= parity_en;
                rx_ptype <= parity_type;
            end else if (tick) begin
                rx_tcnt <= rx_tcnt + 4'd1;
                if (rx_samp && rx_state == R_DATA) rx_sh <= {rx_line, rx_sh[DATA_W-1:1]};
                if (rx_bend && rx_state == R_DATA) rx_bcnt <= rx_bcnt + 4'd1;
                if (rx_samp && rx_state == R_PAR)  rx_pbad <= ((^rx_word) ^ rx_ptype) != rx_line;
            end
        end
    end
endmodule
